ecall_io32: RTL and testbench
=============================

ECALL_IO32 -- requirements
Module: ecall_io32

Interface
REQ-001 Parameter DB_CYCLES, default 100000, number of consecutive stable clock cycles the confirm button must hold before its debounced level changes.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 IORead  input  1  ecall input request from control unit (a7 in 0..3).
REQ-005 IOWrite  input  1  ecall output request from control unit (a7 in 4..5).
REQ-006 rega7  input  32  current value of register a7 (service selector).
REQ-007 rega0  input  32  current value of register a0 (output data).
REQ-008 switch_in  input  16  board switches, asynchronous to clock.
REQ-009 confirm_btn  input  1  raw confirm push-button, active-high, asynchronous, bouncing.
REQ-010 io_rdata  output  32  read data for write-back to a0.
REQ-011 io_stall  output  1  hold PC/pipeline while a read is pending.
REQ-012 io_done  output  1  one-cycle completion pulse for a read or write.
REQ-013 led_out  output  16  LED register.
REQ-014 seg_data  output  32  seven-segment display value register.

Function
REQ-015 switch_in and confirm_btn SHALL each pass a 2-flop synchronizer before any use.
REQ-016 Debouncer: counter SHALL reset to 0 whenever synchronized confirm equals debounced level, increment otherwise; debounced level SHALL toggle and counter clear when counter reaches DB_CYCLES-1.
REQ-017 FSM states: IDLE, WAIT_REL, WAIT_PRESS, DONE.
REQ-018 IDLE with IORead=1: next state WAIT_REL; io_stall SHALL be 1 combinationally in that same cycle.
REQ-019 WAIT_REL: stay until debounced confirm=0, then WAIT_PRESS (prevents a held button completing the read).
REQ-020 WAIT_PRESS: on debounced 0->1 transition, capture read data into io_rdata and go to DONE.
REQ-021 Read data by rega7 (sampled at capture): 0 -> synchronized switch[7:0] zero-extended; 1 -> switch[7:0] sign-extended from bit 7; 2 -> switch[15:0] zero-extended; 3 -> switch[15:8] zero-extended.
REQ-022 DONE: io_stall=0, io_done=1 for exactly one cycle, io_rdata valid; next state IDLE unconditionally, regardless of IORead (CPU advances at end of DONE cycle).
REQ-023 io_stall SHALL equal (IDLE and IORead) or WAIT_REL or WAIT_PRESS; 0 in DONE.
REQ-024 io_rdata SHALL hold its value until the next capture.
REQ-025 IDLE with IOWrite=1 and IORead=0: at next edge, rega7=4 -> led_out<=rega0[15:0]; rega7=5 -> seg_data<=rega0; io_done=1 in the cycle after; no stall; FSM stays IDLE.
REQ-026 IORead and IOWrite both 1: IORead SHALL take priority; no output register update.
REQ-027 IOWrite with rega7 not 4 or 5: no register update, no io_done.
REQ-028 IOWrite while not in IDLE SHALL be ignored.
REQ-029 rega7 changes during WAIT_* SHALL not abort the read; value at capture selects data.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state IDLE, io_rdata=0, led_out=0, seg_data=0, io_done=0, debounce counter=0, debounced level=0, synchronizer flops=0.
REQ-031 Reset asserted mid-read SHALL abandon the read; after release io_stall follows REQ-023 only.

Verification (DB_CYCLES=4)
REQ-032 IORead=1, rega7=0, switch_in=16'h00A5, confirm released then pressed cleanly -> io_stall=1 from request cycle until DONE; io_done one pulse; io_rdata=32'h000000A5.
REQ-033 Same with rega7=1, switch_in=16'h0085 -> io_rdata=32'hFFFFFF85; rega7=3, switch_in=16'hC300 -> 32'h000000C3.
REQ-034 Confirm held high when IORead arrives -> no completion until release then press; glitch shorter than 4 cycles -> no completion.
REQ-035 IOWrite=1, rega7=4, rega0=32'h1234ABCD -> led_out=16'hABCD next edge, io_done pulse, io_stall never 1; rega7=5 -> seg_data=32'h1234ABCD.
REQ-036 reset_n pulsed low while in WAIT_PRESS -> all outputs 0 immediately; later press without IORead -> no io_done.

Source files
------------

// File: rtl/ecall_io32.sv
// ecall I/O unit: switch reads gated by a debounced confirm press,
// LED / seven-segment writes, and the pipeline stall for pending reads.
module ecall_io32 #(
    parameter int DB_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        IORead,
    input  logic        IOWrite,
    input  logic [31:0] rega7,
    input  logic [31:0] rega0,
    input  logic [15:0] switch_in,
    input  logic        confirm_btn,
    output logic [31:0] io_rdata,
    output logic        io_stall,
    output logic        io_done,
    output logic [15:0] led_out,
    output logic [31:0] seg_data
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_REL,
        WAIT_PRESS,
        DONE
    } state_t;

    state_t state, state_n;

    logic [15:0]   sw_s1, sw_s2;
    logic          btn_s1, btn_s2;
    logic [CW-1:0] db_cnt;
    logic          db_lvl;
    logic          wr_done;
    logic          busy;
    logic          capture;
    logic          wr_en;
    logic [31:0]   rd_val;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            sw_s1  <= switch_in;
            sw_s2  <= sw_s1;
            btn_s1 <= confirm_btn;
            btn_s2 <= btn_s1;
        end
    end

    // Level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt <= '0;
            db_lvl <= 1'b0;
        end else if (btn_s2 == db_lvl) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_MAX) begin
            db_cnt <= '0;
            db_lvl <= ~db_lvl;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (IORead) begin
                    state_n = WAIT_REL;
                    busy    = 1'b1;
                end
            end
            WAIT_REL: begin
                busy = 1'b1;
                if (!db_lvl) state_n = WAIT_PRESS;
            end
            // Only reachable with db_lvl low, so a high level is a fresh press.
            WAIT_PRESS: begin
                busy = 1'b1;
                if (db_lvl) begin
                    state_n = DONE;
                    capture = 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (rega7)
            32'd0: rd_val = {24'b0, sw_s2[7:0]};
            32'd1: rd_val = {{24{sw_s2[7]}}, sw_s2[7:0]};
            32'd2: rd_val = {16'b0, sw_s2};
            32'd3: rd_val = {24'b0, sw_s2[15:8]};
            default: rd_val = '0;
        endcase
    end

    assign wr_en = (state == IDLE) && IOWrite && !IORead;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            io_rdata <= '0;
            led_out  <= '0;
            seg_data <= '0;
            wr_done  <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            if (capture) io_rdata <= rd_val;
            if (wr_en && rega7 == 32'd4) begin
                led_out <= rega0[15:0];
                wr_done <= 1'b1;
            end
            if (wr_en && rega7 == 32'd5) begin
                seg_data <= rega0;
                wr_done  <= 1'b1;
            end
        end
    end

    assign io_stall = reset_n & busy;
    assign io_done  = (state == DONE) | wr_done;

endmodule

// File: tb/tb_ecall_io32.sv
// Scoreboard bench for ecall_io32: stimulus queues expected completions,
// a forked monitor checks each io_done pulse against the queue head.
module tb_ecall_io32;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        IORead;
    logic        IOWrite;
    logic [31:0] rega7;
    logic [31:0] rega0;
    logic [15:0] switch_in;
    logic        confirm_btn;
    logic [31:0] io_rdata;
    logic        io_stall;
    logic        io_done;
    logic [15:0] led_out;
    logic [31:0] seg_data;

    always #5 clock = ~clock;

    ecall_io32 #(.DB_CYCLES(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .IORead      (IORead),
        .IOWrite     (IOWrite),
        .rega7       (rega7),
        .rega0       (rega0),
        .switch_in   (switch_in),
        .confirm_btn (confirm_btn),
        .io_rdata    (io_rdata),
        .io_stall    (io_stall),
        .io_done     (io_done),
        .led_out     (led_out),
        .seg_data    (seg_data)
    );

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (io_done === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_done: io_done=1, expected 0");
                end else begin
                    e = sbq.pop_front();
                    check("done_nostall", {31'b0, io_stall}, 32'd0);
                    case (e.kind)
                        0:       check("rdata", io_rdata, e.val);
                        1:       check("led", {16'b0, led_out}, e.val);
                        default: check("seg", seg_data, e.val);
                    endcase
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_done(output bit ok, output bit stall_ok);
        ok       = 1'b0;
        stall_ok = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock);
            if (io_done) ok = 1'b1;
            else if (!io_stall) stall_ok = 1'b0;
        end
    endtask

    task automatic count_done(input int n, output int nd);
        nd = 0;
        repeat (n) begin
            @(negedge clock);
            if (io_done) nd++;
        end
    endtask

    task automatic press_and_finish(input string name);
        bit ok, sok;
        confirm_btn = 1'b1;
        wait_done(ok, sok);
        IORead = 1'b0;
        check({name, "_done_seen"}, {31'b0, ok}, 32'd1);
        check({name, "_stall_held"}, {31'b0, sok}, 32'd1);
        if (!ok) sbq.delete();
        step(1);
        confirm_btn = 1'b0;
        step(10);
    endtask

    task automatic do_read(input logic [31:0] a7, input logic [15:0] sw,
                           input logic [31:0] expv, input string name);
        @(posedge clock);
        #1;
        switch_in = sw;
        rega7     = a7;
        IORead    = 1'b1;
        #1;
        check({name, "_stall_req"}, {31'b0, io_stall}, 32'd1);
        sbq.push_back('{0, expv});
        step(2);
        press_and_finish(name);
    endtask

    task automatic do_write(input logic [31:0] a7, input logic [31:0] a0,
                            input int kind, input logic [31:0] expv,
                            input bit expect_done, input string name);
        @(posedge clock);
        #1;
        rega7   = a7;
        rega0   = a0;
        IOWrite = 1'b1;
        if (expect_done) sbq.push_back('{kind, expv});
        #1;
        check({name, "_stall0"}, {31'b0, io_stall}, 32'd0);
        step(1);
        IOWrite = 1'b0;
        check({name, "_stall1"}, {31'b0, io_stall}, 32'd0);
        step(3);
    endtask

    initial begin
        int nd;
        reset_n     = 1'b0;
        IORead      = 1'b0;
        IOWrite     = 1'b0;
        rega7       = '0;
        rega0       = '0;
        switch_in   = '0;
        confirm_btn = 1'b0;
        fork
            monitor();
        join_none
        step(2);
        check("rst_rdata", io_rdata, 32'd0);
        check("rst_stall", {31'b0, io_stall}, 32'd0);
        check("rst_done", {31'b0, io_done}, 32'd0);
        check("rst_led", {16'b0, led_out}, 32'd0);
        check("rst_seg", seg_data, 32'd0);
        reset_n = 1'b1;
        step(2);

        do_read(32'd0, 16'h00A5, 32'h0000_00A5, "rd_zext8");
        do_read(32'd1, 16'h0085, 32'hFFFF_FF85, "rd_sext8");
        do_read(32'd3, 16'hC300, 32'h0000_00C3, "rd_hi8");

        // Button already held when the read arrives, plus a short glitch.
        confirm_btn = 1'b1;
        step(10);
        switch_in = 16'h5A3C;
        rega7     = 32'd2;
        IORead    = 1'b1;
        count_done(15, nd);
        check("held_no_done", nd, 32'd0);
        check("held_stall", {31'b0, io_stall}, 32'd1);
        step(1);
        confirm_btn = 1'b0;
        step(10);
        confirm_btn = 1'b1;
        step(2);
        confirm_btn = 1'b0;
        count_done(12, nd);
        check("glitch_no_done", nd, 32'd0);
        check("glitch_stall", {31'b0, io_stall}, 32'd1);
        sbq.push_back('{0, 32'h0000_5A3C});
        press_and_finish("rd_held");

        do_write(32'd4, 32'h1234_ABCD, 1, 32'h0000_ABCD, 1'b1, "wr_led");
        do_write(32'd5, 32'h1234_ABCD, 2, 32'h1234_ABCD, 1'b1, "wr_seg");
        do_write(32'd6, 32'h0000_0000, 0, 32'd0, 1'b0, "wr_bad");
        check("wr_bad_led", {16'b0, led_out}, 32'h0000_ABCD);
        check("wr_bad_seg", seg_data, 32'h1234_ABCD);

        // Read and write together; selector changes while waiting.
        @(posedge clock);
        #1;
        switch_in = 16'hC300;
        rega7     = 32'd4;
        rega0     = 32'hFFFF_0000;
        IORead    = 1'b1;
        IOWrite   = 1'b1;
        #1;
        check("both_stall", {31'b0, io_stall}, 32'd1);
        step(1);
        IOWrite = 1'b0;
        rega7   = 32'd3;
        sbq.push_back('{0, 32'h0000_00C3});
        step(2);
        press_and_finish("rd_both");
        check("both_led_kept", {16'b0, led_out}, 32'h0000_ABCD);

        // Reset in the middle of a read.
        @(posedge clock);
        #1;
        switch_in = 16'h00A5;
        rega7     = 32'd0;
        IORead    = 1'b1;
        step(5);
        reset_n = 1'b0;
        #1;
        check("mid_rst_stall", {31'b0, io_stall}, 32'd0);
        check("mid_rst_done", {31'b0, io_done}, 32'd0);
        check("mid_rst_rdata", io_rdata, 32'd0);
        check("mid_rst_led", {16'b0, led_out}, 32'd0);
        check("mid_rst_seg", seg_data, 32'd0);
        IORead = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        confirm_btn = 1'b1;
        count_done(15, nd);
        check("post_rst_no_done", nd, 32'd0);
        check("post_rst_stall", {31'b0, io_stall}, 32'd0);
        confirm_btn = 1'b0;
        step(10);

        check("queue_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
